// File: rtl/btn_pkg.sv
// Shared constants and types for the button conditioning path.
// Timing defaults are derived from the 36 MHz pixel clock.
package btn_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;

  typedef logic [4:0] btn_vec_t;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} rpt_state_t;

  localparam int PIXEL_CLK_HZ        = 36_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = PIXEL_CLK_HZ / 100;
  localparam int DEF_REPEAT_DELAY    = PIXEL_CLK_HZ / 2;
  localparam int DEF_REPEAT_PERIOD   = PIXEL_CLK_HZ / 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: synchroniser, debounce filter, press/release pulses
// and an auto-repeat pulse generator, all outputs registered.
module button_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic pixel_clk,
  input  logic sim_rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic level_next
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DB_W-1:0]        db_cnt, db_cnt_n;
  logic                   stable_n, press_n, release_n, repeat_n;
  rpt_state_t             state, state_n;
  logic [RPT_W-1:0]       rpt_cnt, rpt_cnt_n;

  assign sync       = sync_q[SYNC_STAGES-1];
  assign level_next = stable_n;

  always_ff @(posedge pixel_clk) begin
    if (sim_rst) begin
      sync_q      <= '0;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
      state       <= IDLE;
      rpt_cnt     <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      db_cnt      <= db_cnt_n;
      btn_level   <= stable_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_repeat  <= repeat_n;
      state       <= state_n;
      rpt_cnt     <= rpt_cnt_n;
    end
  end

  always_comb begin
    stable_n = btn_level;
    db_cnt_n = db_cnt;
    if (sync == btn_level) begin
      db_cnt_n = '0;
    end else if (db_cnt == DB_LAST) begin
      stable_n = sync;
      db_cnt_n = '0;
    end else begin
      db_cnt_n = db_cnt + 1'b1;
    end
    press_n   = stable_n & ~btn_level;
    release_n = ~stable_n & btn_level;
  end

  // The FSM advances on the registered pulses; the repeat pulse is then
  // precomputed from the state the channel will be in during the next cycle.
  always_comb begin
    state_n   = state;
    rpt_cnt_n = rpt_cnt;
    unique case (state)
      IDLE: begin
        if (btn_press) begin
          rpt_cnt_n = '0;
          state_n   = repeat_en ? DELAY : HOLD;
        end
      end
      DELAY: begin
        if (!repeat_en) begin
          state_n = HOLD;
        end else if (rpt_cnt == DELAY_LAST) begin
          rpt_cnt_n = '0;
          state_n   = REPEAT;
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!repeat_en) begin
          state_n = HOLD;
        end else if (rpt_cnt == PERIOD_LAST) begin
          rpt_cnt_n = '0;
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end
      HOLD: ;
      default: state_n = IDLE;
    endcase
    if (btn_release) begin
      state_n   = IDLE;
      rpt_cnt_n = '0;
    end

    repeat_n = 1'b0;
    if (!release_n) begin
      unique case (state_n)
        IDLE:    repeat_n = press_n;
        DELAY:   repeat_n = (rpt_cnt_n == DELAY_LAST);
        REPEAT:  repeat_n = (rpt_cnt_n == PERIOD_LAST);
        default: repeat_n = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions all raw buttons for game_console: one button_debounce per
// channel plus a registered any-button-down flag.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BUTTONS       = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 pixel_clk,
  input  logic                 sim_rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic                 repeat_en,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_repeat,
  output logic                 any_pressed
);

  logic [N_BUTTONS-1:0] level_next;

  for (genvar ch = 0; ch < N_BUTTONS; ch++) begin : g_chan
    button_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .pixel_clk  (pixel_clk),
      .sim_rst    (sim_rst),
      .btn_raw    (btn_raw[ch]),
      .repeat_en  (repeat_en),
      .btn_level  (btn_level[ch]),
      .btn_press  (btn_press[ch]),
      .btn_release(btn_release[ch]),
      .btn_repeat (btn_repeat[ch]),
      .level_next (level_next[ch])
    );
  end

  // Built from next-state levels so it lines up with btn_level.
  always_ff @(posedge pixel_clk) begin
    if (sim_rst) any_pressed <= 1'b0;
    else         any_pressed <= |level_next;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw board/simulator buttons (c, u, d, r, l) before they reach game_console.
- Each channel gets a synchroniser, a debounce filter, one-cycle press/release pulses and an auto-repeat pulse stream, so game logic acts once per press or at a controlled hold rate.
- Sits between the button inputs and game_console in both the board top and the SDL simulation top, clocked by pixel_clk (36 MHz).

Parameters:
- N_BUTTONS, 5, number of independent channels; bit i of every vector is channel i.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..3.
- DEBOUNCE_CYCLES, 360000, cycles an input must stay stable before it is accepted (10 ms at 36 MHz); must be ≥1.
- REPEAT_DELAY, 18000000, hold cycles from press to first auto-repeat pulse (500 ms); must be ≥1.
- REPEAT_PERIOD, 3600000, cycles between later auto-repeat pulses (100 ms); must be ≥1.

Ports:
- pixel_clk  input  1  sole clock.
- sim_rst  input  1  reset, synchronous, active-high.
- btn_raw  input  N_BUTTONS  raw, asynchronous button levels, active-high.
- repeat_en  input  1  global auto-repeat enable.
- btn_level  output  N_BUTTONS  debounced level.
- btn_press  output  N_BUTTONS  one-cycle pulse on a debounced 0→1 transition.
- btn_release  output  N_BUTTONS  one-cycle pulse on a debounced 1→0 transition.
- btn_repeat  output  N_BUTTONS  one-cycle pulse on press, then auto-repeat pulses while held.
- any_pressed  output  1  OR of btn_level.

Behaviour:
- Reset (sim_rst=1 at a rising edge): clear all synchroniser flops, stable levels, counters and FSMs. All outputs read 0 from that edge on. Reset in mid-count or mid-repeat aborts the operation; nothing resumes afterwards.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops; sync[i] is the last flop.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If sync == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← sync, counter ← 0.
  - Else: counter ← counter+1.
- Debounce latency: a raw change held steady shows on btn_level at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the change, counting the first sampling edge as 1. A change shorter than DEBOUNCE_CYCLES cycles at sync produces no output change.
- btn_level = stable. Outputs are registered; there is no combinational path from btn_raw to any output.
- Edge pulses: btn_press / btn_release are high for exactly the one cycle in which btn_level has just changed, i.e. the same cycle btn_level first shows the new value.
- Repeat FSM, per channel (rpt_cnt width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)):
  - IDLE: on btn_press, btn_repeat=1 that cycle; rpt_cnt ← 0; go to DELAY if repeat_en=1, else HOLD.
  - DELAY: rpt_cnt increments. When rpt_cnt == REPEAT_DELAY-1: pulse btn_repeat, rpt_cnt ← 0, go to REPEAT.
  - REPEAT: rpt_cnt increments. When rpt_cnt == REPEAT_PERIOD-1: pulse, rpt_cnt ← 0.
  - HOLD: no pulses.
  - From any state, btn_release → IDLE that edge; no repeat pulse is issued in the release cycle.
  - repeat_en=0 while in DELAY or REPEAT → HOLD. repeat_en rising while in HOLD has no effect until the next press.
  - First auto-pulse timing: it occurs exactly REPEAT_DELAY cycles after the press pulse; later pulses are REPEAT_PERIOD apart.
- Channels are fully independent; simultaneous presses on several channels each produce their own pulses in the same cycle.
- any_pressed is the registered OR of the next-state stable levels, so it is cycle-aligned with btn_level.

Decomposition:
- Package btn_pkg holds:
  - channel index constants BTN_C=0, BTN_U=1, BTN_D=2, BTN_R=3, BTN_L=4;
  - typedef btn_vec_t = logic [4:0];
  - repeat FSM enum rpt_state_t {IDLE, DELAY, REPEAT, HOLD};
  - default timing constants derived from PIXEL_CLK_HZ = 36_000_000.
- Sub-module button_debounce: single channel covering sync, debounce, edge detection and repeat FSM, with the same parameters minus N_BUTTONS. button_conditioner generate-instantiates it N_BUTTONS times and ORs the levels.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset: hold sim_rst 3 cycles with btn_raw=5'h1F → every output 0 throughout; release reset with raw held → btn_level=5'h1F at the 6th edge after reset deassert, with btn_press=5'h1F for that single cycle.
- Glitch rejection: btn_raw[1] high for 3 cycles, then low → btn_level, btn_press and btn_repeat stay 0.
- Clean press: btn_raw[0] rises and holds → btn_level[0] at the 6th edge. btn_press[0] and btn_repeat[0] pulse in that cycle; btn_repeat[0] pulses again 10 cycles later, then every 3 cycles.
- Release mid-repeat: drop btn_raw[0] while in REPEAT → btn_release[0] pulses 6 edges later; no btn_repeat pulse at or after the release cycle.
- repeat_en=0: press btn_raw[4] and hold 40 cycles → exactly one btn_repeat[4] pulse, coincident with btn_press[4].
- Simultaneous/independent channels: raise btn_raw[2] and btn_raw[3] in the same cycle, and sim_rst mid-DELAY on channel 2 → identical pulses on both channels before reset; after reset all outputs 0 until a fresh 6-edge debounce completes.
